// File: rtl/service_window_scheduler.sv
// Round-robin scheduler sharing one service window among N requesters.
// SWSTAT follows the design-wide polarity: 1 = window closed, 0 = window open.
module service_window_scheduler #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int GUARD = 2,
  parameter int IDW   = $clog2(N)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N-1:0]     REQ,
  input  logic [N*W-1:0]   SWLEN,
  output logic [N-1:0]     GNT,
  output logic [IDW-1:0]   ACTIVE_ID,
  output logic             SWSTAT,
  output logic             DONE
);

  localparam int GW = (GUARD < 2) ? 1 : $clog2(GUARD + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [W-1:0]    len_r, len_s;
  logic [W-1:0]    cnt_r, cnt_s;
  logic [GW-1:0]   gcnt_r, gcnt_s;
  logic [IDW-1:0]  ptr_r, ptr_s;
  logic [N-1:0]    gnt_r, gnt_s;
  logic [IDW-1:0]  active_id_r, active_id_s;
  logic            swstat_r, swstat_s;
  logic            done_r, done_s;

  logic [N-1:0]    elig_s;
  logic            found_s;
  logic [IDW-1:0]  winner_s;
  logic [IDW-1:0]  cand_s;
  logic [W-1:0]    winner_len_s;
  logic            decide_s;

  // Eligibility and rotating first-eligible search starting at the pointer
  always_comb begin
    elig_s       = {N{1'b0}};
    found_s      = 1'b0;
    winner_s     = {IDW{1'b0}};
    cand_s       = {IDW{1'b0}};
    winner_len_s = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      elig_s[i] = REQ[i] && (SWLEN[i*W +: W] != {W{1'b0}});
    end
    for (int off = 0; off < N; off++) begin
      cand_s = IDW'((int'(ptr_r) + off) % N);
      if (!found_s && elig_s[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (winner_s == IDW'(i)) begin
        winner_len_s = SWLEN[i*W +: W];
      end else begin
        winner_len_s = winner_len_s;
      end
    end
  end

  // Next-state and registered-output values
  always_comb begin
    state_s     = state_r;
    len_s       = len_r;
    cnt_s       = cnt_r;
    gcnt_s      = gcnt_r;
    ptr_s       = ptr_r;
    gnt_s       = gnt_r;
    active_id_s = active_id_r;
    swstat_s    = swstat_r;
    done_s      = 1'b0;
    decide_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        decide_s = 1'b1;
      end
      ST_OPEN: begin
        // Full length reached or owner released early
        if ((cnt_r == len_r) || !REQ[active_id_r]) begin
          gnt_s    = {N{1'b0}};
          swstat_s = 1'b1;
          done_s   = 1'b1;
          gcnt_s   = GW'(1);
          state_s  = ST_GUARD;
        end else begin
          cnt_s = cnt_r + W'(1);
        end
      end
      ST_GUARD: begin
        if (gcnt_r == GW'(GUARD)) begin
          decide_s = 1'b1;
        end else begin
          gcnt_s = gcnt_r + GW'(1);
        end
      end
      default: begin
        state_s  = ST_IDLE;
        gnt_s    = {N{1'b0}};
        swstat_s = 1'b1;
      end
    endcase

    if (decide_s) begin
      if (found_s) begin
        len_s       = winner_len_s;
        cnt_s       = W'(1);
        gnt_s       = N'(1) << winner_s;
        active_id_s = winner_s;
        swstat_s    = 1'b0;
        ptr_s       = (winner_s == IDW'(N - 1)) ? {IDW{1'b0}} : winner_s + IDW'(1);
        state_s     = ST_OPEN;
      end else begin
        gnt_s    = {N{1'b0}};
        swstat_s = 1'b1;
        state_s  = ST_IDLE;
      end
    end else begin
      decide_s = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      len_r       <= {W{1'b0}};
      cnt_r       <= {W{1'b0}};
      gcnt_r      <= {GW{1'b0}};
      ptr_r       <= {IDW{1'b0}};
      gnt_r       <= {N{1'b0}};
      active_id_r <= {IDW{1'b0}};
      swstat_r    <= 1'b1;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      len_r       <= len_s;
      cnt_r       <= cnt_s;
      gcnt_r      <= gcnt_s;
      ptr_r       <= ptr_s;
      gnt_r       <= gnt_s;
      active_id_r <= active_id_s;
      swstat_r    <= swstat_s;
      done_r      <= done_s;
    end
  end

  assign GNT       = gnt_r;
  assign ACTIVE_ID = active_id_r;
  assign SWSTAT    = swstat_r;
  assign DONE      = done_r;

  service_window_scheduler_chk #(.N(N)) u_chk (
    .CLK    (CLK),
    .RST    (RST),
    .GNT    (GNT),
    .SWSTAT (SWSTAT),
    .DONE   (DONE)
  );

endmodule

// Output consistency properties for the scheduler.
module service_window_scheduler_chk #(
  parameter int N = 4
) (
  input logic         CLK,
  input logic         RST,
  input logic [N-1:0] GNT,
  input logic         SWSTAT,
  input logic         DONE
);

  a_gnt_onehot0: assert property (@(posedge CLK) disable iff (RST) $onehot0(GNT));
  a_stat_match:  assert property (@(posedge CLK) disable iff (RST) SWSTAT == (GNT == {N{1'b0}}));
  a_done_closed: assert property (@(posedge CLK) disable iff (RST) DONE |-> SWSTAT);

endmodule

// File: doc/service_window_scheduler.md
# service_window_scheduler

Round-robin scheduler that shares a single service window between up to N requesters. It arbitrates pending requests, grants the window to one requester for that requester's programmed length, enforces a guard gap between consecutive windows, and reports the window status on SWSTAT. SWSTAT uses the design-wide convention: 1 = window closed, 0 = window open. The block sits between the requesting units and the downstream logic that consumes SWSTAT.

## Interface
- N, 4: number of requesters (2..8)
- W, 8: window-length / counter width
- GUARD, 2: closed cycles forced between windows (≥1)
- IDW, $clog2(N): requester-ID width (derived)

- CLK  in  1  clock; all logic on posedge
- RST  in  1  reset; synchronous, active-high
- REQ  in  N  per-requester request level
- SWLEN  in  N*W  packed window lengths; requester i uses bits [i*W +: W]
- GNT  out  N  one-hot grant; high for the whole open window
- ACTIVE_ID  out  IDW  index of the current or last granted requester
- SWSTAT  out  1  0 = window open, 1 = closed
- DONE  out  1  one-cycle pulse on the first cycle after a window closes

## Operation
- States: IDLE, OPEN, GUARD. All outputs are registered.
- Eligible requester: REQ[i]=1 and SWLEN_i≠0. A requester with zero length is never granted.
- Decision edge: any edge in IDLE, or the edge ending the last GUARD cycle.
- At a decision edge with ≥1 eligible requester:
  - Search starts at pointer PTR and proceeds upward with wrap-around; the first eligible requester wins.
  - The winner's SWLEN is latched into LEN. Counter CNT←1.
  - Outputs: GNT←onehot(winner), ACTIVE_ID←winner, SWSTAT←0, PTR←(winner+1) mod N.
  - State→OPEN.
- At a decision edge with no eligible requester: state→IDLE (or stays IDLE), SWSTAT=1, GNT=0.
- OPEN:
  - Window closes when CNT==LEN, or when the owner deasserts REQ (early release).
  - Otherwise CNT←CNT+1.
  - On close: GNT←0, SWSTAT←1, DONE←1 for one cycle, guard counter←1, state→GUARD.
- GUARD lasts exactly GUARD cycles, with SWSTAT=1 and GNT=0. It always ends in a decision edge.
- Input changes during a window:
  - SWLEN changes are ignored for the active window (LEN is latched).
  - REQ from non-owners is ignored until the next decision edge.
- Counter arithmetic is W-bit, and CNT never exceeds LEN, so there is no wrap. A window of SWLEN=2^W−1 is legal.
- Reset (RST=1 at an edge, from any state, including mid-window):
  - state=IDLE, GNT=0, SWSTAT=1, DONE=0, ACTIVE_ID=0, PTR=0, CNT=0.
  - The open window closes at that edge. No DONE pulse is produced.
- Simultaneous close and RST: RST wins, so DONE=0.

## Timing
- Grant latency: REQ sampled at the decision edge, GNT/SWSTAT updated at that same edge, so they are visible in the next cycle.
- Window length: GNT high and SWSTAT low for exactly LEN cycles (full window), or for k cycles when the owner drops REQ in window cycle k.
- Early release: REQ sampled low in window cycle k closes the window at the end of cycle k.
- DONE: asserted in the first GUARD cycle.
- Back-to-back windows are separated by exactly GUARD closed cycles. Full-window period per grant is LEN+GUARD cycles.
- ACTIVE_ID holds its value through GUARD and IDLE until the next grant.

## Test plan
- Reset state, then single request. Hold RST for 2 cycles and check outputs: GNT=0, SWSTAT=1, DONE=0, ACTIVE_ID=0. Then, with GUARD=2, REQ=0001 and SWLEN0=3, requested from cycle t:
  - GNT=0001 and SWSTAT=0 in cycles t+1..t+3
  - DONE=1 in t+4 only
  - SWSTAT=1 in t+4..t+5
  - regrant in t+6..t+8
- Round-robin: REQ=1111 held, all lengths 1, GUARD=2 → grants in order 0,1,2,3,0, one every 3 cycles; ACTIVE_ID follows the same sequence.
- Zero length and skipping: REQ=0110 with SWLEN1=0 and SWLEN2=4 → only requester 2 is granted, 4-cycle windows; requester 1 is never granted.
- Early release: SWLEN0=10, REQ[0] dropped in window cycle 3 → GNT low after 3 cycles, DONE pulses once, then the GUARD gap.
- Latching and reset:
  - SWLEN0 changed from 5 to 2 during the window → window still lasts 5 cycles.
  - RST asserted in window cycle 2 → GNT=0 and SWSTAT=1 at the next cycle, no DONE pulse, PTR=0, so requester 0 wins the next arbitration against requester 3.
